// File: rtl/vram_arbiter_if.sv
// Bus bundle between the VRAM arbiter, its three masters and the single-port RAM.
// slave = arbiter side, master = requesters plus RAM model side.
interface vram_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 4
);
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_valid;
    logic [DATA_W-1:0] disp_rdata;

    logic              c0_req,    c1_req;
    logic              c0_we,     c1_we;
    logic [ADDR_W-1:0] c0_addr,   c1_addr;
    logic [DATA_W-1:0] c0_wdata,  c1_wdata;
    logic              c0_gnt,    c1_gnt;
    logic              c0_rvalid, c1_rvalid;
    logic [DATA_W-1:0] c0_rdata,  c1_rdata;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    logic              starve;

    modport slave (
        input  disp_req, disp_addr,
        input  c0_req, c0_we, c0_addr, c0_wdata,
        input  c1_req, c1_we, c1_addr, c1_wdata,
        input  ram_rdata,
        output disp_valid, disp_rdata,
        output c0_gnt, c0_rvalid, c0_rdata,
        output c1_gnt, c1_rvalid, c1_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata,
        output starve
    );

    modport master (
        output disp_req, disp_addr,
        output c0_req, c0_we, c0_addr, c0_wdata,
        output c1_req, c1_we, c1_addr, c1_wdata,
        output ram_rdata,
        input  disp_valid, disp_rdata,
        input  c0_gnt, c0_rvalid, c0_rdata,
        input  c1_gnt, c1_rvalid, c1_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        input  starve
    );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display has fixed top priority, two game clients share
// the remaining slots round-robin; read data returns two cycles after the request.
module vram_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 4,
    parameter int STARVE_MAX = 1023
) (
    input  logic          clk,
    input  logic          rst,
    vram_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_DISP = 2'd1,
        TAG_C0   = 2'd2,
        TAG_C1   = 2'd3
    } tag_t;

    localparam logic [15:0] STARVE_LIM = 16'(STARVE_MAX);

    logic [1:0]        w_req;
    logic [1:0]        w_gnt;
    logic [1:0]        w_over;

    logic              r_rr_c1;
    logic              r_ram_en;
    logic              r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_wdata;
    tag_t              r_tag;
    logic              r_disp_valid, r_c0_valid, r_c1_valid;
    logic [DATA_W-1:0] r_disp_hold, r_c0_hold, r_c1_hold;
    logic              r_starve;

    assign w_req = {bus.c1_req, bus.c0_req};

    // Display takes the slot outright; otherwise a lone requester wins, ties go to r_rr_c1.
    always_comb begin
        w_gnt = 2'b00;
        if (rst && !bus.disp_req) begin
            if (w_req[0] && (!w_req[1] || !r_rr_c1))
                w_gnt[0] = 1'b1;
            else if (w_req[1])
                w_gnt[1] = 1'b1;
        end
    end

    assign bus.c0_gnt = w_gnt[0];
    assign bus.c1_gnt = w_gnt[1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rr_c1      <= 1'b0;
            r_ram_en     <= 1'b0;
            r_ram_we     <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_wdata  <= '0;
            r_tag        <= TAG_NONE;
            r_disp_valid <= 1'b0;
            r_c0_valid   <= 1'b0;
            r_c1_valid   <= 1'b0;
            r_disp_hold  <= '0;
            r_c0_hold    <= '0;
            r_c1_hold    <= '0;
            r_starve     <= 1'b0;
        end else begin
            r_ram_en <= bus.disp_req | (|w_gnt);
            if (bus.disp_req) begin
                r_ram_we    <= 1'b0;
                r_ram_addr  <= bus.disp_addr;
                r_ram_wdata <= '0;
                r_tag       <= TAG_DISP;
            end else if (w_gnt[0]) begin
                r_ram_we    <= bus.c0_we;
                r_ram_addr  <= bus.c0_addr;
                r_ram_wdata <= bus.c0_wdata;
                r_tag       <= bus.c0_we ? TAG_NONE : TAG_C0;
            end else if (w_gnt[1]) begin
                r_ram_we    <= bus.c1_we;
                r_ram_addr  <= bus.c1_addr;
                r_ram_wdata <= bus.c1_wdata;
                r_tag       <= bus.c1_we ? TAG_NONE : TAG_C1;
            end else begin
                r_ram_we    <= 1'b0;
                r_tag       <= TAG_NONE;
            end

            if (w_gnt[0])
                r_rr_c1 <= 1'b1;
            else if (w_gnt[1])
                r_rr_c1 <= 1'b0;

            // The tag stage lines up with the RAM's own one-cycle read register.
            r_disp_valid <= (r_tag == TAG_DISP);
            r_c0_valid   <= (r_tag == TAG_C0);
            r_c1_valid   <= (r_tag == TAG_C1);

            if (r_disp_valid) r_disp_hold <= bus.ram_rdata;
            if (r_c0_valid)   r_c0_hold   <= bus.ram_rdata;
            if (r_c1_valid)   r_c1_hold   <= bus.ram_rdata;

            if (|w_over)
                r_starve <= 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_wait
            logic [15:0] r_wait;
            logic [15:0] w_wait_next;

            always_comb begin
                w_wait_next = 16'd0;
                if (w_req[gi] && !w_gnt[gi])
                    w_wait_next = (r_wait == 16'hFFFF) ? r_wait : r_wait + 16'd1;
            end

            // Flag on the count being written, so starve is visible in the first cycle past the limit.
            assign w_over[gi] = (w_wait_next > STARVE_LIM);

            always_ff @(posedge clk) begin
                if (!rst)
                    r_wait <= 16'd0;
                else
                    r_wait <= w_wait_next;
            end
        end
    endgenerate

    // Returned data is forwarded straight from the RAM in its valid cycle, then held.
    assign bus.disp_rdata = r_disp_valid ? bus.ram_rdata : r_disp_hold;
    assign bus.c0_rdata   = r_c0_valid   ? bus.ram_rdata : r_c0_hold;
    assign bus.c1_rdata   = r_c1_valid   ? bus.ram_rdata : r_c1_hold;

    assign bus.disp_valid = r_disp_valid;
    assign bus.c0_rvalid  = r_c0_valid;
    assign bus.c1_rvalid  = r_c1_valid;
    assign bus.ram_en     = r_ram_en;
    assign bus.ram_we     = r_ram_we;
    assign bus.ram_addr   = r_ram_addr;
    assign bus.ram_wdata  = r_ram_wdata;
    assign bus.starve     = r_starve;

endmodule
